mem_fetch_unit: RTL and testbench
=================================

MEM_FETCH_UNIT -- requirements
Module: mem_fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 9, memory address width.
REQ-002 Parameter DATA_W, default 16, instruction/data word width.
REQ-003 Parameter LED_ADDR, default 9'h100, memory-mapped LED write address.
REQ-004 Parameter SW_ADDR, default 9'h140, memory-mapped switch read address.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 load_pc  in  1  increment PC at next edge.
REQ-008 reset_pc  in  1  clear PC at next edge.
REQ-009 load_ir  in  1  capture read_data into IR at next edge.
REQ-010 addr_sel  in  1  1: mem_addr=PC; 0: mem_addr=data address register.
REQ-011 load_addr  in  1  capture datapath_out[8:0] into data address register.
REQ-012 mem_cmd  in  2  00 MNONE, 01 MREAD, 10 MWRITE, 11 illegal.
REQ-013 datapath_out  in  16  datapath C result: data address source and write data.
REQ-014 ram_rdata  in  16  synchronous RAM read data, valid one cycle after ram_rd_en.
REQ-015 switches  in  8  slide-switch inputs.
REQ-016 ram_addr  out  8  mem_addr[7:0].
REQ-017 ram_rd_en / ram_wr_en  out  1 each  RAM read/write strobes.
REQ-018 ram_wdata  out  16  equals datapath_out.
REQ-019 read_data  out  16  read word (mdata) to datapath and IR.
REQ-020 instr  out  16  instruction register.
REQ-021 pc  out  9  program counter.
REQ-022 leds  out  8  LED register.
REQ-023 mem_ready  out  1  current command complete / read_data valid.
REQ-024 cmd_err  out  1  sticky illegal-command flag.

Function
REQ-025 mem_addr SHALL be combinational: addr_sel ? pc : data_addr; RAM region is mem_addr[8]==0.
REQ-026 PC: reset_pc SHALL clear pc to 0 with priority over load_pc; load_pc SHALL set pc to pc+1 modulo 512 (9'h1FF wraps to 9'h000).
REQ-027 MREAD in RAM region SHALL drive ram_rd_en=1 combinationally for every cycle the command is present.
REQ-028 MREAD at SW_ADDR SHALL register {8'h00, switches} at the edge; any other non-RAM read SHALL register 16'h0000.
REQ-029 A read-pending register SHALL record (address, region) at each MREAD edge; read_data SHALL be ram_rdata if pending region is RAM, else the registered I/O value.
REQ-030 mem_ready SHALL be 1 during MREAD only when the previous cycle was MREAD to the same mem_addr (read latency exactly one cycle); an address change or a gap restarts the read.
REQ-031 mem_ready SHALL be 1 during MNONE and MWRITE (single-cycle write).
REQ-032 MWRITE in RAM region SHALL assert ram_wr_en=1 for that cycle with ram_wdata=datapath_out.
REQ-033 MWRITE at LED_ADDR SHALL load leds <= datapath_out[7:0] at the edge; other non-RAM writes SHALL be ignored.
REQ-034 mem_cmd 11 SHALL produce no RAM strobe, no LED update, mem_ready=0, and set cmd_err until reset.
REQ-035 load_ir SHALL load instr <= read_data regardless of mem_ready; load_addr and load_ir SHALL be independent of each other and of mem_cmd.
REQ-036 ram_rd_en and ram_wr_en SHALL never be 1 together.

Reset
REQ-037 reset SHALL asynchronously clear pc, data_addr, instr, leds, read-pending register, I/O read register, and cmd_err to 0.
REQ-038 During reset: ram_rd_en=0, ram_wr_en=0, mem_ready=0 regardless of inputs; an in-flight read SHALL be discarded.
REQ-039 First edge after reset release SHALL behave as a fresh cycle with no pending read.

Verification
REQ-040 Fetch: pc=0, RAM[0]=16'hD105, addr_sel=1, MREAD held 2 cycles, load_ir in cycle 2 -> ram_rd_en both cycles, mem_ready 0 then 1, instr=16'hD105.
REQ-041 PC wrap and priority: pc=9'h1FF, load_pc -> pc=0; load_pc=reset_pc=1 with pc=5 -> pc=0.
REQ-042 Store/LED: datapath_out=16'h0100, load_addr; then datapath_out=16'h00A5, addr_sel=0, MWRITE -> leds=8'hA5, ram_wr_en=0; repeat at address 9'h010 -> ram_wr_en=1, ram_addr=8'h10, ram_wdata=16'h00A5.
REQ-043 Switch read: switches=8'h3C, data_addr=9'h140, MREAD 2 cycles -> read_data=16'h003C, mem_ready=1 in cycle 2; unmapped 9'h180 -> 16'h0000.
REQ-044 Address change mid-read: MREAD at 9'h004 then 9'h005 next cycle -> mem_ready stays 0 in second cycle, 1 in third.
REQ-045 Illegal/reset: mem_cmd=11 -> cmd_err=1, no strobes; assert reset mid-MREAD -> all outputs 0 immediately, cmd_err cleared.

Source files
------------

// File: rtl/mem_fetch_unit.sv
// Memory fetch/access unit: PC, IR, data address register, RAM strobes and
// memory-mapped LED/switch I/O with one-cycle read latency tracking.
module mem_fetch_unit #(
  parameter int unsigned       ADDR_W   = 9,
  parameter int unsigned       DATA_W   = 16,
  parameter logic [ADDR_W-1:0] LED_ADDR = 9'h100,
  parameter logic [ADDR_W-1:0] SW_ADDR  = 9'h140
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_pc,
  input  logic              reset_pc,
  input  logic              load_ir,
  input  logic              addr_sel,
  input  logic              load_addr,
  input  logic [1:0]        mem_cmd,
  input  logic [DATA_W-1:0] datapath_out,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic [7:0]        switches,
  output logic [ADDR_W-2:0] ram_addr,
  output logic              ram_rd_en,
  output logic              ram_wr_en,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [DATA_W-1:0] read_data,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] pc,
  output logic [7:0]        leds,
  output logic              mem_ready,
  output logic              cmd_err
);

  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] data_addr_q, data_addr_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0] io_rdata_q, io_rdata_d;
  logic [7:0]        leds_q, leds_d;
  logic              pend_valid_q, pend_valid_d;
  logic              pend_ram_q, pend_ram_d;
  logic              cmd_err_q, cmd_err_d;

  logic [ADDR_W-1:0] mem_addr;
  logic              in_ram;
  logic              is_rd;
  logic              is_wr;

  assign mem_addr  = addr_sel ? pc_q : data_addr_q;
  assign in_ram    = ~mem_addr[ADDR_W-1];
  assign is_rd     = (mem_cmd == MREAD);
  assign is_wr     = (mem_cmd == MWRITE);

  assign ram_addr  = mem_addr[ADDR_W-2:0];
  assign ram_rd_en = ~reset & is_rd & in_ram;
  assign ram_wr_en = ~reset & is_wr & in_ram;
  assign ram_wdata = datapath_out;
  assign read_data = pend_ram_q ? ram_rdata : io_rdata_q;

  assign instr     = instr_q;
  assign pc        = pc_q;
  assign leds      = leds_q;
  assign cmd_err   = cmd_err_q;

  // A read completes on its second consecutive cycle at an unchanged address
  always_comb begin
    mem_ready = 1'b0;
    if (!reset) begin
      unique case (mem_cmd)
        MNONE:   mem_ready = 1'b1;
        MWRITE:  mem_ready = 1'b1;
        MREAD:   mem_ready = pend_valid_q && (pend_addr_q == mem_addr);
        default: mem_ready = 1'b0;
      endcase
    end
  end

  always_comb begin
    pc_d         = pc_q;
    data_addr_d  = data_addr_q;
    instr_d      = instr_q;
    leds_d       = leds_q;
    io_rdata_d   = io_rdata_q;
    pend_valid_d = is_rd;
    pend_addr_d  = pend_addr_q;
    pend_ram_d   = pend_ram_q;
    cmd_err_d    = cmd_err_q | (mem_cmd == 2'b11);

    if (reset_pc)     pc_d = '0;
    else if (load_pc) pc_d = pc_q + ADDR_W'(1);

    if (load_addr) data_addr_d = datapath_out[ADDR_W-1:0];
    if (load_ir)   instr_d     = read_data;

    if (is_wr && (mem_addr == LED_ADDR)) leds_d = datapath_out[7:0];

    // Region and address of each read are kept so read_data selects the right source
    if (is_rd) begin
      pend_addr_d = mem_addr;
      pend_ram_d  = in_ram;
      if (!in_ram) io_rdata_d = (mem_addr == SW_ADDR) ? DATA_W'(switches) : '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q         <= '0;
      data_addr_q  <= '0;
      instr_q      <= '0;
      leds_q       <= '0;
      io_rdata_q   <= '0;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      pend_ram_q   <= 1'b0;
      cmd_err_q    <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      data_addr_q  <= data_addr_d;
      instr_q      <= instr_d;
      leds_q       <= leds_d;
      io_rdata_q   <= io_rdata_d;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      pend_ram_q   <= pend_ram_d;
      cmd_err_q    <= cmd_err_d;
    end
  end

endmodule

// File: tb/tb_mem_fetch_unit.sv
// Self-checking bench for mem_fetch_unit: directed scenarios plus randomized
// traffic against a transaction-level memory/register model.
module tb_mem_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, load_pc, reset_pc, load_ir, addr_sel, load_addr;
  logic [1:0]  mem_cmd;
  logic [15:0] datapath_out, ram_rdata;
  logic [7:0]  switches;
  logic [7:0]  ram_addr;
  logic        ram_rd_en, ram_wr_en;
  logic [15:0] ram_wdata, read_data, instr;
  logic [8:0]  pc;
  logic [7:0]  leds;
  logic        mem_ready, cmd_err;

  int n_checks = 0;
  int n_fail   = 0;

  mem_fetch_unit dut (
    .clk(clk), .reset(reset), .load_pc(load_pc), .reset_pc(reset_pc),
    .load_ir(load_ir), .addr_sel(addr_sel), .load_addr(load_addr),
    .mem_cmd(mem_cmd), .datapath_out(datapath_out), .ram_rdata(ram_rdata),
    .switches(switches), .ram_addr(ram_addr), .ram_rd_en(ram_rd_en),
    .ram_wr_en(ram_wr_en), .ram_wdata(ram_wdata), .read_data(read_data),
    .instr(instr), .pc(pc), .leds(leds), .mem_ready(mem_ready), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  // Synchronous RAM environment with a back-door preload port
  logic [15:0] ram [256];
  logic        pl_en = 1'b0;
  logic [7:0]  pl_addr = '0;
  logic [15:0] pl_data = '0;
  always @(posedge clk) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    else if (ram_wr_en) ram[ram_addr] <= ram_wdata;
    if (ram_rd_en) ram_rdata <= ram[ram_addr];
  end

  task automatic idle();
    load_pc = 0; reset_pc = 0; load_ir = 0; addr_sel = 0; load_addr = 0;
    mem_cmd = 2'b00; datapath_out = '0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_daddr(input logic [15:0] a);
    idle(); datapath_out = a; load_addr = 1; tick(); idle();
  endtask

  task automatic test_reset();
    reset = 1; idle(); switches = 8'h00; mem_cmd = 2'b01; addr_sel = 1; load_pc = 1; load_ir = 1;
    #1;
    n_checks++; if (ram_rd_en !== 1'b0) begin n_fail++; $display("FAIL rst_rd_en: got %b expected 0", ram_rd_en); end
    n_checks++; if (mem_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b expected 0", mem_ready); end
    tick();
    n_checks++; if (pc !== 9'h000) begin n_fail++; $display("FAIL rst_pc: got %h expected 000", pc); end
    n_checks++; if (instr !== 16'h0000) begin n_fail++; $display("FAIL rst_instr: got %h expected 0000", instr); end
    n_checks++; if ({leds, cmd_err} !== 9'h0) begin n_fail++; $display("FAIL rst_leds_err: got %h expected 000", {leds, cmd_err}); end
    n_checks++; if (read_data !== 16'h0000) begin n_fail++; $display("FAIL rst_rdata: got %h expected 0000", read_data); end
    reset = 0; load_pc = 0; load_ir = 0;
    #1;
    n_checks++; if ({ram_rd_en, mem_ready} !== 2'b10) begin n_fail++; $display("FAIL post_rst_fresh: got %b expected 10", {ram_rd_en, mem_ready}); end
    tick();
    n_checks++; if (mem_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready: got %b expected 1", mem_ready); end
    idle(); tick();
  endtask

  task automatic test_fetch();
    set_daddr(16'h0000);
    datapath_out = 16'hD105; mem_cmd = 2'b10; #1;
    n_checks++; if (ram_wr_en !== 1'b1) begin n_fail++; $display("FAIL fetch_store_wr: got %b expected 1", ram_wr_en); end
    tick(); idle(); reset_pc = 1; tick(); idle();
    addr_sel = 1; mem_cmd = 2'b01; #1;
    n_checks++; if ({ram_rd_en, mem_ready} !== 2'b10) begin n_fail++; $display("FAIL fetch_c1: got %b expected 10", {ram_rd_en, mem_ready}); end
    tick(); load_ir = 1; #1;
    n_checks++; if ({ram_rd_en, mem_ready} !== 2'b11) begin n_fail++; $display("FAIL fetch_c2: got %b expected 11", {ram_rd_en, mem_ready}); end
    n_checks++; if (read_data !== 16'hD105) begin n_fail++; $display("FAIL fetch_rdata: got %h expected d105", read_data); end
    tick(); idle(); #1;
    n_checks++; if (instr !== 16'hD105) begin n_fail++; $display("FAIL fetch_instr: got %h expected d105", instr); end
  endtask

  task automatic test_pc_wrap();
    idle(); reset_pc = 1; tick(); idle(); load_pc = 1;
    for (int i = 0; i < 511; i++) tick();
    n_checks++; if (pc !== 9'h1FF) begin n_fail++; $display("FAIL pc_max: got %h expected 1ff", pc); end
    tick();
    n_checks++; if (pc !== 9'h000) begin n_fail++; $display("FAIL pc_wrap: got %h expected 000", pc); end
    for (int i = 0; i < 5; i++) tick();
    n_checks++; if (pc !== 9'h005) begin n_fail++; $display("FAIL pc_five: got %h expected 005", pc); end
    reset_pc = 1; tick(); idle();
    n_checks++; if (pc !== 9'h000) begin n_fail++; $display("FAIL pc_prio: got %h expected 000", pc); end
  endtask

  task automatic test_store_led();
    set_daddr(16'h0100);
    datapath_out = 16'h00A5; mem_cmd = 2'b10; #1;
    n_checks++; if ({ram_wr_en, mem_ready} !== 2'b01) begin n_fail++; $display("FAIL led_strobe: got %b expected 01", {ram_wr_en, mem_ready}); end
    tick(); idle();
    n_checks++; if (leds !== 8'hA5) begin n_fail++; $display("FAIL led_value: got %h expected a5", leds); end
    set_daddr(16'h0010);
    datapath_out = 16'h00A5; mem_cmd = 2'b10; #1;
    n_checks++; if ({ram_wr_en, ram_addr, ram_wdata} !== {1'b1, 8'h10, 16'h00A5}) begin n_fail++; $display("FAIL ram_store: got %b %h %h expected 1 10 00a5", ram_wr_en, ram_addr, ram_wdata); end
    tick(); idle();
    n_checks++; if (leds !== 8'hA5) begin n_fail++; $display("FAIL led_hold: got %h expected a5", leds); end
  endtask

  task automatic test_switch_read();
    switches = 8'h3C; set_daddr(16'h0140);
    mem_cmd = 2'b01; #1;
    n_checks++; if ({ram_rd_en, mem_ready} !== 2'b00) begin n_fail++; $display("FAIL sw_c1: got %b expected 00", {ram_rd_en, mem_ready}); end
    tick();
    n_checks++; if ({read_data, mem_ready} !== {16'h003C, 1'b1}) begin n_fail++; $display("FAIL sw_c2: got %h %b expected 003c 1", read_data, mem_ready); end
    set_daddr(16'h0180); mem_cmd = 2'b01; tick();
    n_checks++; if ({read_data, mem_ready} !== {16'h0000, 1'b1}) begin n_fail++; $display("FAIL unmapped_rd: got %h %b expected 0000 1", read_data, mem_ready); end
    idle(); tick();
  endtask

  task automatic test_addr_change();
    set_daddr(16'h0004);
    mem_cmd = 2'b01; datapath_out = 16'h0005; load_addr = 1; #1;
    n_checks++; if (mem_ready !== 1'b0) begin n_fail++; $display("FAIL chg_c1: got %b expected 0", mem_ready); end
    tick(); load_addr = 0; #1;
    n_checks++; if ({ram_addr, mem_ready} !== {8'h05, 1'b0}) begin n_fail++; $display("FAIL chg_c2: got %h %b expected 05 0", ram_addr, mem_ready); end
    tick();
    n_checks++; if (mem_ready !== 1'b1) begin n_fail++; $display("FAIL chg_c3: got %b expected 1", mem_ready); end
    idle(); tick();
  endtask

  task automatic test_illegal_reset();
    set_daddr(16'h0005);
    mem_cmd = 2'b11; datapath_out = 16'h0100; #1;
    n_checks++; if ({ram_rd_en, ram_wr_en, mem_ready} !== 3'b000) begin n_fail++; $display("FAIL ill_strobes: got %b expected 000", {ram_rd_en, ram_wr_en, mem_ready}); end
    tick(); idle();
    n_checks++; if ({cmd_err, leds} !== {1'b1, 8'hA5}) begin n_fail++; $display("FAIL ill_err: got %b %h expected 1 a5", cmd_err, leds); end
    load_pc = 1; tick(); tick(); load_pc = 0;
    addr_sel = 1; mem_cmd = 2'b01; tick();
    reset = 1; #1;
    n_checks++; if ({ram_rd_en, ram_wr_en, mem_ready, cmd_err} !== 4'b0000) begin n_fail++; $display("FAIL midrd_rst_flags: got %b expected 0000", {ram_rd_en, ram_wr_en, mem_ready, cmd_err}); end
    n_checks++; if ({pc, instr, leds, read_data, ram_addr} !== '0) begin n_fail++; $display("FAIL midrd_rst_regs: got %h %h %h %h %h expected zeros", pc, instr, leds, read_data, ram_addr); end
    tick(); reset = 0; idle(); tick();
  endtask

  // Transaction-level reference: architectural registers plus a word-array memory
  logic [15:0] m_mem [256];
  logic [8:0]  m_pc, m_daddr, m_prev_addr;
  logic [15:0] m_instr, m_rdval;
  logic [7:0]  m_leds;
  logic        m_err, m_prev_rd;

  task automatic model_reset();
    m_pc = 0; m_daddr = 0; m_instr = 0; m_rdval = 0; m_leds = 0; m_err = 0; m_prev_rd = 0; m_prev_addr = 0;
  endtask

  task automatic test_random();
    logic [8:0]  ea;
    logic        e_rd, e_wr, e_rdy;
    logic [15:0] r;
    reset = 1; idle(); tick(); reset = 0;
    for (int i = 0; i < 256; i++) begin
      pl_en = 1; pl_addr = 8'(i); pl_data = 16'($urandom); m_mem[i] = pl_data; tick();
    end
    pl_en = 0; model_reset();
    for (int n = 0; n < 1500; n++) begin
      if (n == 0 || $urandom_range(0, 1) == 0) begin
        r = 16'($urandom_range(0, 39));
        mem_cmd = (r == 0) ? 2'b11 : (r < 18) ? 2'b01 : (r < 28) ? 2'b10 : 2'b00;
        addr_sel = 1'($urandom); load_addr = ($urandom_range(0, 2) == 0);
        load_pc = ($urandom_range(0, 3) == 0); reset_pc = ($urandom_range(0, 15) == 0);
      end else begin
        load_addr = 0; load_pc = 0; reset_pc = 0;
      end
      case ($urandom_range(0, 4))
        0: datapath_out = 16'h0100 | 16'($urandom_range(0, 255) & 8'h00);
        1: datapath_out = 16'h0140;
        2: datapath_out = 16'h0100 | 16'($urandom_range(0, 255));
        default: datapath_out = 16'($urandom);
      endcase
      load_ir = 1'($urandom); switches = 8'($urandom);
      reset = ($urandom_range(0, 99) == 0);
      if (reset) model_reset();
      #1;
      ea = addr_sel ? m_pc : m_daddr;
      e_rd = !reset && mem_cmd == 2'b01 && !ea[8];
      e_wr = !reset && mem_cmd == 2'b10 && !ea[8];
      e_rdy = !reset && (mem_cmd == 2'b00 || mem_cmd == 2'b10 || (mem_cmd == 2'b01 && m_prev_rd && m_prev_addr == ea));
      n_checks++; if ({ram_rd_en, ram_wr_en} !== {e_rd, e_wr}) begin n_fail++; $display("FAIL rnd_strobes n=%0d: got %b expected %b", n, {ram_rd_en, ram_wr_en}, {e_rd, e_wr}); end
      n_checks++; if (ram_addr !== ea[7:0]) begin n_fail++; $display("FAIL rnd_addr n=%0d: got %h expected %h", n, ram_addr, ea[7:0]); end
      n_checks++; if (mem_ready !== e_rdy) begin n_fail++; $display("FAIL rnd_ready n=%0d: got %b expected %b", n, mem_ready, e_rdy); end
      n_checks++; if (read_data !== m_rdval) begin n_fail++; $display("FAIL rnd_rdata n=%0d: got %h expected %h", n, read_data, m_rdval); end
      n_checks++; if ({pc, instr, leds, cmd_err} !== {m_pc, m_instr, m_leds, m_err}) begin n_fail++; $display("FAIL rnd_regs n=%0d: got %h %h %h %b expected %h %h %h %b", n, pc, instr, leds, cmd_err, m_pc, m_instr, m_leds, m_err); end
      @(posedge clk);
      if (reset) model_reset();
      else begin
        if (load_ir) m_instr = m_rdval;
        if (mem_cmd == 2'b10 && !ea[8]) m_mem[ea[7:0]] = datapath_out;
        if (mem_cmd == 2'b10 && ea == 9'h100) m_leds = datapath_out[7:0];
        if (mem_cmd == 2'b01) m_rdval = !ea[8] ? m_mem[ea[7:0]] : (ea == 9'h140) ? {8'h00, switches} : 16'h0000;
        m_prev_rd = (mem_cmd == 2'b01); m_prev_addr = ea;
        if (mem_cmd == 2'b11) m_err = 1;
        if (reset_pc) m_pc = 0; else if (load_pc) m_pc = m_pc + 9'd1;
        if (load_addr) m_daddr = datapath_out[8:0];
      end
      #1;
    end
    reset = 0; idle();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_pc_wrap();
    test_store_led();
    test_switch_read();
    test_addr_change();
    test_illegal_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
